// File: rtl/vga_cfg_ctrl.sv
// ============================================================================
// vga_cfg_ctrl : UART command parser and register-write sequencer/arbiter
// Optional ACK/NAK echo on the UART transmitter enabled by `define CFG_ECHO_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_cfg_ctrl #(
    parameter int NUM_REGS    = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       rx_perr_i,
    input  logic       btn_req_i,
    input  logic [3:0] btn_addr_i,
    input  logic [7:0] btn_data_i,
    output logic       wr_en_o,
    output logic [3:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       btn_drop_o,
    output logic [7:0] last_hdr_o
`ifdef CFG_ECHO_EN
    ,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    input  logic       tx_busy_i
`endif
);

    localparam logic [3:0]       LAST_ADDR = 4'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_WRITE     = 2'd2,
        S_CLEAR     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       haddr_q, haddr_d;
    logic [3:0]       clr_q, clr_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [7:0]       last_hdr_q, last_hdr_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             pend_q, pend_d;
    logic [3:0]       pend_addr_q, pend_addr_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             btn_drop_q, btn_drop_d;

    logic             fsm_wr;
    logic [3:0]       fsm_addr;
    logic [7:0]       fsm_data;
    logic             drain;

    // FSM writes are launched on the transition so wr_en lines up with WRITE/CLEAR.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        clr_d       = clr_q;
        tmo_d       = tmo_q;
        last_hdr_d  = last_hdr_q;
        frame_err_d = 1'b0;
        fsm_wr      = 1'b0;
        fsm_addr    = '0;
        fsm_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_perr_i || (rx_data_i[7:6] != 2'b11)) begin
                        frame_err_d = 1'b1;
                    end else if (rx_data_i[5:4] == 2'b01) begin
                        haddr_d    = rx_data_i[3:0];
                        last_hdr_d = rx_data_i;
                        tmo_d      = '0;
                        state_d    = S_WAIT_DATA;
                    end else if (rx_data_i[5:4] == 2'b00) begin
                        last_hdr_d = rx_data_i;
                        clr_d      = '0;
                        state_d    = S_CLEAR;
                        fsm_wr     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (rx_valid_i) begin
                    if (rx_perr_i) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        fsm_wr   = 1'b1;
                        fsm_addr = haddr_q;
                        fsm_data = rx_data_i;
                        state_d  = S_WRITE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (clr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    clr_d    = clr_q + 4'd1;
                    fsm_wr   = 1'b1;
                    fsm_addr = clr_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // The button entry only takes the port in cycles the FSM leaves free next cycle.
    always_comb begin
        drain       = pend_q && !fsm_wr;
        pend_d      = pend_q && !drain;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        btn_drop_d  = 1'b0;
        if (btn_req_i) begin
            if (pend_d) begin
                btn_drop_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = btn_addr_i;
                pend_data_d = btn_data_i;
            end
        end
        wr_en_d   = fsm_wr || drain;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (fsm_wr) begin
            wr_addr_d = fsm_addr;
            wr_data_d = fsm_data;
        end else if (drain) begin
            wr_addr_d = pend_addr_q;
            wr_data_d = pend_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            clr_q       <= '0;
            tmo_q       <= '0;
            last_hdr_q  <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            btn_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            clr_q       <= clr_d;
            tmo_q       <= tmo_d;
            last_hdr_q  <= last_hdr_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            btn_drop_q  <= btn_drop_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign frame_err_o = frame_err_q;
    assign btn_drop_o  = btn_drop_q;
    assign last_hdr_o  = last_hdr_q;

`ifdef CFG_ECHO_EN
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic       cmd_done;
    logic       tx_pend_q, tx_pend_d;
    logic [7:0] tx_resp_q, tx_resp_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;

    assign cmd_done = (state_q == S_WRITE) || ((state_q == S_CLEAR) && (clr_q == LAST_ADDR));

    // tx_busy may lag our own start pulse by a cycle, so never launch back-to-back.
    always_comb begin
        tx_pend_d  = tx_pend_q;
        tx_resp_d  = tx_resp_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (tx_pend_q && !tx_busy_i && !tx_start_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = tx_resp_q;
            tx_pend_d  = 1'b0;
        end
        if (cmd_done) begin
            tx_pend_d = 1'b1;
            tx_resp_d = ACK;
        end else if (frame_err_d) begin
            tx_pend_d = 1'b1;
            tx_resp_d = NAK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_pend_q  <= 1'b0;
            tx_resp_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_pend_q  <= tx_pend_d;
            tx_resp_q  <= tx_resp_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
`endif

endmodule

`default_nettype wire
